fifo_drain_stream: RTL and testbench

FIFO_DRAIN_STREAM -- requirements
Module: fifo_drain_stream

---
 rtl/fifo_drain_stream.sv | 94 +++++++++
 tb/tb_fifo_drain_stream.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_stream.sv
// Drains a fall-through FIFO into a valid/ready stream through a 2-entry skid
// buffer, framing the stream into fixed-length packets and counting them.
module fifo_drain_stream #(
  parameter int unsigned Width  = 8,
  parameter int unsigned PktLen = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_fifo_empty,
  input  logic [Width-1:0] i_fifo_data,
  output logic             o_fifo_rd_en,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data,
  output logic             o_last,
  output logic [1:0]       o_level,
  output logic [15:0]      o_pkt_count
);

  localparam int unsigned CntW = (PktLen > 1) ? $clog2(PktLen) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(PktLen - 1);

  logic [Width-1:0] mem [2];
  logic             head_q, head_d;
  logic [1:0]       level_q, level_d;
  logic [CntW-1:0]  wcnt_q, wcnt_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic             tail;
  logic             push;
  logic             pop;

  // Fetch only when there is room; independent of downstream ready.
  assign push = ~i_fifo_empty & (level_q != 2'd2) & ~i_clear & i_rstn;
  assign pop  = o_valid & i_ready & ~i_clear & i_rstn;
  assign tail = head_q ^ level_q[0];

  assign o_fifo_rd_en = push;
  assign o_valid      = (level_q != 2'd0);
  assign o_data       = mem[head_q];
  assign o_last       = o_valid & (wcnt_q == LastIdx);
  assign o_level      = level_q;
  assign o_pkt_count  = pkt_count_q;

  // Next-state for occupancy, head pointer, word and packet counters.
  always_comb begin
    level_d     = level_q;
    head_d      = head_q;
    wcnt_d      = wcnt_q;
    pkt_count_d = pkt_count_q;
    if (i_clear) begin
      level_d = 2'd0;
      wcnt_d  = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + 2'd1;
        2'b01:   level_d = level_q - 2'd1;
        default: level_d = level_q;
      endcase
      if (pop) begin
        head_d = ~head_q;
        if (wcnt_q == LastIdx) begin
          wcnt_d      = '0;
          pkt_count_d = pkt_count_q + 16'd1;
        end else begin
          wcnt_d = wcnt_q + CntW'(1);
        end
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      level_q     <= 2'd0;
      head_q      <= 1'b0;
      wcnt_q      <= '0;
      pkt_count_q <= 16'd0;
    end else begin
      level_q     <= level_d;
      head_q      <= head_d;
      wcnt_q      <= wcnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Buffer storage; contents are not reset, only control state is.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[tail] <= i_fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_drain_stream.sv
// Randomised and directed bench for fifo_drain_stream with a queue-based
// source FIFO, a scoreboard of fetched words and a packet-position model.
module tb_fifo_drain_stream;

  localparam int unsigned W   = 8;
  localparam int unsigned PKT = 4;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_fifo_empty;
  logic [W-1:0] i_fifo_data;
  logic         o_fifo_rd_en;
  logic         i_clear;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_last;
  logic [1:0]   o_level;
  logic [15:0]  o_pkt_count;

  fifo_drain_stream #(.Width(W), .PktLen(PKT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_fifo_empty(i_fifo_empty),
    .i_fifo_data(i_fifo_data), .o_fifo_rd_en(o_fifo_rd_en), .i_clear(i_clear),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_level(o_level), .o_pkt_count(o_pkt_count)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] src[$];   // words still in the upstream FIFO
  logic [W-1:0] sb[$];    // words fetched by the DUT, not yet delivered
  int           n_chk  = 0;
  int           n_fail = 0;
  int           reads  = 0;
  int           widx   = 0;      // position of the next delivered word in its packet
  logic [15:0]  exp_pkt = 16'd0;
  bit           armed  = 1'b0;
  int           force_seq  = 0;
  int           force_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs each cycle, then advance the model for the edge.
  always @(negedge i_clk) begin
    if (force_seen != force_seq) begin
      exp_pkt    = 16'hFFFF;
      force_seen = force_seq;
    end
    if (armed) begin
      chk("level", longint'(o_level), longint'(sb.size()));
      chk("valid", longint'(o_valid), longint'(sb.size() != 0));
      chk("rd_en", longint'(o_fifo_rd_en),
          longint'(!i_fifo_empty && sb.size() < 2 && !i_clear && i_rstn));
      chk("pkt_count", longint'(o_pkt_count), longint'(exp_pkt));
      if (sb.size() != 0) begin
        chk("data", longint'(o_data), longint'(sb[0]));
        chk("last", longint'(o_last), longint'(widx == PKT - 1));
      end else begin
        chk("last_idle", longint'(o_last), 0);
      end
    end
    if (!i_rstn) begin
      sb.delete();
      widx    = 0;
      exp_pkt = 16'd0;
      armed   = 1'b1;
    end else if (i_clear) begin
      sb.delete();
      widx = 0;
    end else if (i_ready && sb.size() != 0) begin
      if (widx == PKT - 1) exp_pkt = exp_pkt + 16'd1;
      widx = (widx + 1) % PKT;
      void'(sb.pop_front());
    end
  end

  // One cycle of stimulus; the upstream FIFO pops when the DUT asserted rd_en.
  task automatic step(input logic rdy, input logic clr, input logic rst, input logic bub);
    logic fetch;
    i_ready      = rdy;
    i_clear      = clr;
    i_rstn       = rst;
    i_fifo_empty = bub || (src.size() == 0);
    i_fifo_data  = (src.size() != 0) ? src[0] : '0;
    @(negedge i_clk);
    fetch = o_fifo_rd_en;
    @(posedge i_clk);
    #1;
    if (fetch && src.size() != 0) begin
      sb.push_back(src.pop_front());
      reads = reads + 1;
    end
  endtask

  task automatic load(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) src.push_back(W'(base + W'(i)));
  endtask

  initial begin
    int r0;
    logic [15:0] pk0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Streaming two full packets
    load(8'h10, 8);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stream_pkts", longint'(o_pkt_count), 2);

    // Backpressure: exactly two reads, head held
    load(8'hA0, 4);
    r0 = reads;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_reads", longint'(reads - r0), 2);
    chk("bp_level", longint'(o_level), 2);
    chk("bp_data", longint'(o_data), 8'hA0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Bubbles: empty toggles every cycle
    load(8'h30, 8);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'(i % 2));

    // Clear mid-packet after two pops with one word buffered
    load(8'hC0, 4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_pre_level", longint'(o_level), 1);
    pk0 = o_pkt_count;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_level", longint'(o_level), 0);
    chk("clr_pkt", longint'(o_pkt_count), longint'(pk0));
    load(8'hC8, 3);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset with a full buffer and a non-empty FIFO
    load(8'hD0, 6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_pre_level", longint'(o_level), 2);
    r0 = reads;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_reads", longint'(reads - r0), 0);
    chk("rst_src_kept", longint'(src.size()), 4);
    chk("rst_level", longint'(o_level), 0);
    chk("rst_valid", longint'(o_valid), 0);
    chk("rst_last", longint'(o_last), 0);
    chk("rst_pkt", longint'(o_pkt_count), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Packet counter wrap from 16'hFFFF
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    force_seq = force_seq + 1;
    load(8'hE0, 4);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap_pkt", longint'(o_pkt_count), 0);

    // Random traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      if (src.size() < 4) load(W'($urandom), 8);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 79) != 0), 1'($urandom_range(0, 3) == 0));
    end

    // Drain everything that is left
    for (int i = 0; i < 300 && (src.size() != 0 || sb.size() != 0); i++)
      step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("drain", longint'(src.size() + sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
